// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button debounce / press counter slice.
package btn_pkg;

  // 20 ms of stability at a 50 MHz system clock.
  localparam int DEBOUNCE_20MS_50MHZ = 1000000;
  // Short debounce window used for simulation.
  localparam int SIM_DEBOUNCE = 8;
  // Press counter width feeding the display stage.
  localparam int CNT_W = 4;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int debounce_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-stage synchronizer followed by an optional debounce filter.
// With DEBOUNCE_CYCLES == 1 the filter is bypassed and the output is the
// last synchronizer flop.
module sync_debounce
  import btn_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = SIM_DEBOUNCE,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage samples the raw asynchronous input.
        always_ff @(posedge clk) begin
          if (rst) sync_reg[0] <= RESET_LEVEL;
          else     sync_reg[0] <= din;
        end
      end else begin : g_chain
        // Remaining stages shift the sample along the chain.
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= RESET_LEVEL;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign sync_out = sync_reg[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 1) begin : g_bypass
      assign dout = sync_out;
    end else begin : g_filter
      localparam int            CW   = debounce_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] count_reg;
      logic          stable_reg;

      // Accept a new level only after it has differed for DEBOUNCE_CYCLES
      // consecutive cycles; any return to the stable level restarts the count.
      always_ff @(posedge clk) begin
        if (rst) begin
          count_reg  <= '0;
          stable_reg <= RESET_LEVEL;
        end else if (sync_out == stable_reg) begin
          count_reg  <= '0;
        end else if (count_reg == LAST) begin
          stable_reg <= sync_out;
          count_reg  <= '0;
        end else begin
          count_reg  <= count_reg + 1'b1;
        end
      end

      assign dout = stable_reg;
    end
  endgenerate

endmodule

// File: rtl/btn_debounce_counter.sv
// Debounced push-button with single-cycle press pulse and wrap-around press
// count for the seven-segment display stage. All outputs are registered.
module btn_debounce_counter
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter int SYNC_STAGES     = 2,
  parameter bit BTN_ACTIVE_LOW  = 1'b0,
  parameter int CNT_W           = btn_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             counterbtn,
  input  logic             rstcountreg,
  output logic             stepup,
  output logic             btnpulse,
  output logic [CNT_W-1:0] countreg
);

  // Polarity is normalised ahead of the synchronizer so the chain and the
  // filter always work in "1 = pressed" terms; a released button resets to 0.
  logic btn_pressed_raw;
  logic clr_n_s;
  logic stepup_d_reg;
  logic btnpulse_reg;
  logic [CNT_W-1:0] countreg_reg;

  assign btn_pressed_raw = counterbtn ^ BTN_ACTIVE_LOW;

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b0)
  ) u_btn (
    .clk (clk),
    .rst (rst),
    .din (btn_pressed_raw),
    .dout(stepup)
  );

  // Clear is a level control, so it only needs synchronizing, not filtering.
  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(1),
    .RESET_LEVEL    (1'b1)
  ) u_clr (
    .clk (clk),
    .rst (rst),
    .din (rstcountreg),
    .dout(clr_n_s)
  );

  // Rising-edge detect on the debounced level drives the pulse and the count;
  // an active clear wins over a simultaneous press.
  always_ff @(posedge clk) begin
    if (rst) begin
      stepup_d_reg <= 1'b0;
      btnpulse_reg <= 1'b0;
      countreg_reg <= '0;
    end else begin
      stepup_d_reg <= stepup;
      btnpulse_reg <= stepup & ~stepup_d_reg;
      if (!clr_n_s)
        countreg_reg <= '0;
      else if (stepup & ~stepup_d_reg)
        countreg_reg <= countreg_reg + 1'b1;
    end
  end

  assign btnpulse = btnpulse_reg;
  assign countreg = countreg_reg;

endmodule

// File: tb/tb_btn_debounce_counter.sv
// Directed bench for btn_debounce_counter with an 8-cycle debounce window.
module tb_btn_debounce_counter;
  import btn_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       counterbtn;
  logic       rstcountreg;
  logic       stepup;
  logic       btnpulse;
  logic [3:0] countreg;

  int check_count = 0;
  int pass_count  = 0;
  int pulse_total = 0;

  btn_debounce_counter #(
    .DEBOUNCE_CYCLES(SIM_DEBOUNCE),
    .SYNC_STAGES    (2),
    .BTN_ACTIVE_LOW (1'b0),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .counterbtn (counterbtn),
    .rstcountreg(rstcountreg),
    .stepup     (stepup),
    .btnpulse   (btnpulse),
    .countreg   (countreg)
  );

  always #5 clk = ~clk;

  // Count every cycle the pulse output is high.
  always @(negedge clk) if (btnpulse) pulse_total++;

  task automatic check(input string tag, input int got, input int exp);
    check_count++;
    if (got == exp) begin
      pass_count++;
      $display("check %-18s got %0d exp %0d ok", tag, got, exp);
    end else begin
      $display("FAIL %-18s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edges until stepup reaches level; gives up at 40 edges.
  task automatic wait_stepup(input logic level, output int lat);
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (stepup !== level && lat < 40);
  endtask

  // Follows one press from the edge the pressed level was applied:
  // 2 sync + 8 debounce edges to stepup, pulse on the next edge, release.
  task automatic complete_press(input int exp_cnt, input string tag);
    int lat;
    int p0;
    p0 = pulse_total;
    wait_stepup(1'b1, lat);
    check({tag, "_rise_lat"}, lat, 10);
    check({tag, "_pulse_pre"}, int'(btnpulse), 0);
    tick(1);
    check({tag, "_pulse"}, int'(btnpulse), 1);
    check({tag, "_count"}, int'(countreg), exp_cnt);
    tick(1);
    check({tag, "_pulse_end"}, int'(btnpulse), 0);
    counterbtn = 1'b0;
    wait_stepup(1'b0, lat);
    check({tag, "_fall_lat"}, lat, 10);
    tick(2);
    check({tag, "_count_rel"}, int'(countreg), exp_cnt);
    check({tag, "_npulses"}, pulse_total - p0, 1);
  endtask

  task automatic press(input int exp_cnt, input string tag);
    counterbtn = 1'b1;
    complete_press(exp_cnt, tag);
  endtask

  initial begin
    int lat;
    int p0;
    bit moved;

    // Reset with the button already held.
    rst = 1'b1; counterbtn = 1'b1; rstcountreg = 1'b1;
    tick(2);
    check("rst_stepup", int'(stepup), 0);
    check("rst_pulse", int'(btnpulse), 0);
    check("rst_count", int'(countreg), 0);
    rst = 1'b0;
    complete_press(1, "held_rst");

    // Clean press.
    tick(3);
    press(2, "clean");

    // Bounce: 3-cycle phases never reach the 8-cycle window.
    moved = 1'b0;
    for (int p = 0; p < 10; p++) begin
      counterbtn = (p % 2 == 0);
      repeat (3) begin
        tick(1);
        if (stepup) moved = 1'b1;
      end
    end
    check("bounce_stepup", int'(moved), 0);
    check("bounce_count", int'(countreg), 2);
    press(3, "bounce");

    // Clear held low across a press: count stays at 0, pulse still fires.
    rstcountreg = 1'b0;
    tick(3);
    check("clr_count", int'(countreg), 0);
    press(0, "clr_press");
    rstcountreg = 1'b1;
    tick(3);

    // Wrap-around over 16 presses.
    p0 = pulse_total;
    for (int i = 1; i <= 16; i++)
      press(i % 16, $sformatf("wrap%0d", i));
    check("wrap_pulses", pulse_total - p0, 16);

    // Build up to 5, then a one-cycle clear pulse.
    for (int i = 1; i <= 5; i++)
      press(i, $sformatf("five%0d", i));
    rstcountreg = 1'b0;
    tick(1);
    rstcountreg = 1'b1;
    check("clrpulse_before", int'(countreg), 5);
    tick(2);
    check("clrpulse_after", int'(countreg), 0);

    // Reset in the middle of a debounce with the button still held.
    counterbtn = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    check("middeb_stepup", int'(stepup), 0);
    check("middeb_count", int'(countreg), 0);
    rst = 1'b0;
    complete_press(1, "middeb");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Hard stop in case a wait above never resolves.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $display("%0d/%0d checks passed", pass_count, check_count + 1);
    $fatal(1);
  end

endmodule

// File: doc/btn_debounce_counter.md
Name: btn_debounce_counter

Overview:
Upstream stage of the seven-segment hex display block. Takes the raw push-button and the raw count-clear button, then synchronizes and debounces them. Produces a clean press level, a single-cycle press pulse, and a 4-bit wrap-around press count that the display stage decodes onto the second digit. This replaces direct edge sampling of the raw button in the display logic.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clock cycles needed to accept a button level change (20 ms at 50 MHz); minimum 2.
SYNC_STAGES, 2, flip-flop stages in each input synchronizer; minimum 2.
BTN_ACTIVE_LOW, 0, 1 = counterbtn reads 0 when pressed; 0 = counterbtn reads 1 when pressed.
CNT_W, 4, press counter width.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-high reset.
counterbtn  input  1  raw, asynchronous push-button.
rstcountreg  input  1  raw, asynchronous count clear, active low.
stepup  output  1  debounced press level; 1 = pressed.
btnpulse  output  1  one-cycle pulse on each accepted press.
countreg  output  CNT_W  press count, fed to the display stage.

Behaviour:
- All state is sampled on the rising edge of clk. Reset is synchronous.
- With rst=1 at an edge:
  - stepup=0, btnpulse=0, countreg=0, debounce counter=0.
  - Button synchronizer stages load the "released" level.
  - Clear synchronizer stages load 1 (clear inactive).
- Synchronizers: counterbtn passes through SYNC_STAGES flip-flops, then is inverted if BTN_ACTIVE_LOW=1, giving btn_s (1 = pressed). rstcountreg passes through its own SYNC_STAGES flip-flops, giving clr_n_s.
- Debounce counter: ceil(log2(DEBOUNCE_CYCLES)) bits.
  - btn_s == stepup: counter cleared to 0.
  - btn_s != stepup and counter < DEBOUNCE_CYCLES-1: counter increments.
  - btn_s != stepup and counter == DEBOUNCE_CYCLES-1: stepup <= btn_s, counter cleared.
  - Net effect: stepup changes only after btn_s has differed for exactly DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce back to the stepup level restarts the count from 0.
- Latency: from a clean raw transition to the stepup change is SYNC_STAGES + DEBOUNCE_CYCLES cycles (±1 for raw-input sampling phase).
- Press detect: stepup_d is a registered copy of stepup.
  - btnpulse is registered: btnpulse <= stepup & ~stepup_d.
  - btnpulse is high for exactly one cycle, the cycle after stepup rises.
  - Releases never pulse.
- Counter update, evaluated at each edge:
  - clr_n_s == 0: countreg <= 0. Clear has priority over an increment in the same cycle; that press is lost.
  - else if stepup & ~stepup_d: countreg <= countreg + 1, modulo 2^CNT_W. So 15 -> 0 with CNT_W=4, with no flag.
  - else: countreg holds.
- countreg therefore updates on the same edge that raises btnpulse.
- Clear held low: countreg stays 0. Presses during the clear are not counted and not queued. Debounce and btnpulse keep running.
- Button held indefinitely: exactly one increment per press.
- Reset asserted mid-debounce or mid-press: all state returns to reset values at that edge. A button still held after reset releases counts as a new press once stable for DEBOUNCE_CYCLES. This is intentional: one count after reset.
- No combinational path from any input to any output. All outputs come straight from flip-flops.

Decomposition:
- Shared package btn_pkg holds:
  - DEBOUNCE_20MS_50MHZ = 1000000
  - SIM_DEBOUNCE = 8
  - CNT_W = 4
  - clog2-based width helper for the debounce counter.
- One sub-module, sync_debounce (parameters SYNC_STAGES, DEBOUNCE_CYCLES, RESET_LEVEL): synchronizer, debounce counter and stable-level register.
  - Instantiate once for counterbtn.
  - The clear path uses the synchronizer only (DEBOUNCE_CYCLES bypass = 1).
- The top level adds inversion, stepup_d, btnpulse and countreg.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, SYNC_STAGES=2, BTN_ACTIVE_LOW=0.
1. Reset: rst=1 for 2 cycles with counterbtn=1 -> stepup=0, btnpulse=0, countreg=0. After release, stepup=1 at cycle 10 (±1), btnpulse for 1 cycle, countreg=1.
2. Clean press: counterbtn 0->1, held 20 cycles -> stepup rises 10 (±1) cycles later, btnpulse high exactly 1 cycle, countreg 0->1. Release -> stepup falls 10 cycles later, no pulse, countreg stays 1.
3. Bounce: counterbtn toggles every 3 cycles for 30 cycles, then steady 1 -> no stepup change during toggling, exactly one pulse after the steady level, countreg +1.
4. Wrap-around: 16 clean presses -> countreg steps 1..15 then 0. btnpulse count = 16.
5. Clear priority: rstcountreg held 0 while stepup rises -> countreg=0 after the sync latency, btnpulse still 1 cycle. With countreg=5, pulse rstcountreg low for 1 cycle -> countreg=0 two cycles later.
6. Reset mid-debounce: counterbtn high for 5 cycles then rst=1 for 1 cycle, button still held -> the counter restarts and stepup rises 10 cycles after rst deasserts.
